// File: rtl/chess_timer_pkg.sv
// rtl/chess_timer_pkg.sv - shared types and constants for the chess timer minutes stage
package chess_timer_pkg;

    localparam int MAX_MIN = 99;
    localparam int MIN_W   = 7;
    localparam int SEC_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/toggle_detect.sv
// rtl/toggle_detect.sv - turns the seconds-stage toggle carry into a one-cycle borrow pulse
module toggle_detect (
    input  logic clk,
    input  logic reset,
    input  logic sec_carry,
    output logic borrow
);

    logic carry_q;

    // Track the carry level every cycle, reset included, so that releasing
    // reset never sees a stale level and reports a borrow that did not happen.
    always_ff @(posedge clk) begin
        carry_q <= sec_carry;
    end

    // Any level change is one seconds wrap; nothing is reported while in reset.
    assign borrow = ~reset & (sec_carry ^ carry_q);

endmodule

// File: rtl/counter_min.sv
// rtl/counter_min.sv - minutes countdown stage with run/pause/expire control and preset load
module counter_min #(
    parameter int MAX_MIN = chess_timer_pkg::MAX_MIN,
    parameter int MIN_W   = chess_timer_pkg::MIN_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sec_carry,
    input  logic [chess_timer_pkg::SEC_W-1:0] sec_value,
    input  logic                              load,
    input  logic [MIN_W-1:0]                  preset_min,
    input  logic                              run,
    output logic [MIN_W-1:0]                  minutes,
    output logic                              running,
    output logic                              flag,
    output logic                              flag_pulse
);

    import chess_timer_pkg::*;

    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

    state_t           state_q, state_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic             flag_q, flag_d;
    logic             pulse_q, pulse_d;
    logic             borrow;
    logic             min_zero;
    logic             sec_zero;
    logic [MIN_W-1:0] preset_clamped;

    toggle_detect u_toggle_detect (
        .clk       (clk),
        .reset     (reset),
        .sec_carry (sec_carry),
        .borrow    (borrow)
    );

    assign min_zero       = (min_q == '0);
    assign sec_zero       = (sec_value == '0);
    assign preset_clamped = (preset_min > MAX_MIN_V) ? MAX_MIN_V : preset_min;

    // Next state and next minutes; load overrides everything, and in RUNNING
    // a pause request wins over expiry and decrement in the same cycle.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        flag_d  = flag_q;
        if (load) begin
            state_d = ST_IDLE;
            min_d   = preset_clamped;
            flag_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    if (run) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (!run) begin
                        state_d = ST_PAUSED;
                    end else if (min_zero && (borrow || sec_zero)) begin
                        state_d = ST_EXPIRED;
                        flag_d  = 1'b1;
                    end else if (borrow) begin
                        min_d = min_q - MIN_W'(1);
                    end
                end
                ST_EXPIRED: begin
                    min_d  = '0;
                    flag_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // The strobe is registered so it lines up with the first EXPIRED cycle.
    always_comb begin
        pulse_d = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
    end

    // State register; reset dominates load, run and borrow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            min_q   <= '0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
        end
    end

    assign minutes    = min_q;
    assign running    = (state_q == ST_RUNNING);
    assign flag       = flag_q;
    assign flag_pulse = pulse_q;

endmodule

// File: tb/tb_counter_min.sv
// tb/tb_counter_min.sv - scoreboard bench for counter_min
module tb_counter_min;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_carry;
    logic [5:0] sec_value;
    logic       load;
    logic [6:0] preset_min;
    logic       run;
    logic [6:0] minutes;
    logic       running;
    logic       flag;
    logic       flag_pulse;

    typedef struct {
        string      name;
        logic [6:0] m;
        logic       r;
        logic       f;
        logic       p;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    counter_min #(.MAX_MIN(99), .MIN_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .sec_carry  (sec_carry),
        .sec_value  (sec_value),
        .load       (load),
        .preset_min (preset_min),
        .run        (run),
        .minutes    (minutes),
        .running    (running),
        .flag       (flag),
        .flag_pulse (flag_pulse)
    );

    always #5 clk = ~clk;

    // Monitor: compare every pending expectation against the outputs at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if ({minutes, running, flag, flag_pulse} !== {e.m, e.r, e.f, e.p}) begin
                n_bad++;
                $display("FAIL %s: got min=%0d run=%0b flag=%0b pulse=%0b, want min=%0d run=%0b flag=%0b pulse=%0b",
                         e.name, minutes, running, flag, flag_pulse, e.m, e.r, e.f, e.p);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int m, input bit r, input bit f, input bit p);
        exp_t e;
        e.name = name;
        e.m    = 7'(m);
        e.r    = r;
        e.f    = f;
        e.p    = p;
        sb.push_back(e);
    endtask

    task automatic step(input string name, input int m, input bit r, input bit f, input bit p);
        cyc();
        expect_out(name, m, r, f, p);
    endtask

    task automatic toggle();
        sec_carry = ~sec_carry;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sec_carry = 1'b0; sec_value = 6'd30;
        load = 1'b0; preset_min = 7'd0; run = 1'b0;
        cyc();
        step("reset", 0, 0, 0, 0);
        reset = 1'b0;
        step("idle_after_reset", 0, 0, 0, 0);

        // load 3, run, one toggle -> 2
        load = 1'b1; preset_min = 7'd3;
        step("load3", 3, 0, 0, 0);
        load = 1'b0; run = 1'b1;
        step("run_start", 3, 1, 0, 0);
        toggle();
        step("dec_to_2", 2, 1, 0, 0);
        step("hold_2", 2, 1, 0, 0);

        // clamp, with run held high: load wins, RUNNING next cycle
        load = 1'b1; preset_min = 7'd120;
        step("clamp_99", 99, 0, 0, 0);
        load = 1'b0;
        step("run_after_load", 99, 1, 0, 0);

        // pause ignores borrows
        load = 1'b1; preset_min = 7'd4; run = 1'b0;
        step("load4", 4, 0, 0, 0);
        load = 1'b0; run = 1'b1;
        step("run4", 4, 1, 0, 0);
        run = 1'b0;
        step("paused", 4, 0, 0, 0);
        toggle();
        step("paused_toggle1", 4, 0, 0, 0);
        toggle();
        step("paused_toggle2", 4, 0, 0, 0);
        run = 1'b1;
        step("resume", 4, 1, 0, 0);
        toggle();
        step("dec_to_3", 3, 1, 0, 0);

        // load in the same cycle as a borrow
        load = 1'b1; preset_min = 7'd5; run = 1'b0;
        step("load5", 5, 0, 0, 0);
        load = 1'b0; run = 1'b1;
        step("run5", 5, 1, 0, 0);
        load = 1'b1; preset_min = 7'd10; toggle();
        step("load_beats_borrow", 10, 0, 0, 0);
        load = 1'b0; run = 1'b0;
        step("no_late_dec", 10, 0, 0, 0);

        // expiry via sec_value reaching 0 at minutes 0
        load = 1'b1; preset_min = 7'd1; sec_value = 6'd30;
        step("load1", 1, 0, 0, 0);
        load = 1'b0; run = 1'b1;
        step("run1", 1, 1, 0, 0);
        toggle();
        step("dec_to_0", 0, 1, 0, 0);
        step("zero_hold", 0, 1, 0, 0);
        sec_value = 6'd0;
        step("expire", 0, 0, 1, 1);
        step("pulse_one_cycle", 0, 0, 1, 0);
        toggle(); sec_value = 6'd59;
        step("expired_ignores_borrow", 0, 0, 1, 0);
        run = 1'b0;
        step("expired_ignores_run0", 0, 0, 1, 0);
        run = 1'b1;
        step("expired_ignores_run1", 0, 0, 1, 0);

        // expiry via borrow at minutes 0
        load = 1'b1; preset_min = 7'd0; sec_value = 6'd30;
        step("load_clears_flag", 0, 0, 0, 0);
        load = 1'b0;
        step("run0", 0, 1, 0, 0);
        toggle();
        step("borrow_at_zero", 0, 0, 1, 1);
        step("borrow_pulse_end", 0, 0, 1, 0);

        // reset mid-count while sec_carry goes high
        load = 1'b1; preset_min = 7'd7; run = 1'b0;
        step("load7", 7, 0, 0, 0);
        load = 1'b0; run = 1'b1;
        if (sec_carry) toggle();
        step("run7", 7, 1, 0, 0);
        reset = 1'b1; toggle();
        step("reset_mid", 0, 0, 0, 0);
        step("reset_hold", 0, 0, 0, 0);
        reset = 1'b0; load = 1'b1; preset_min = 7'd2;
        step("post_reset_load", 2, 0, 0, 0);
        load = 1'b0; reset = 1'b1;
        step("reset_again", 0, 0, 0, 0);
        reset = 1'b0;
        step("post_reset_run", 0, 1, 0, 0);
        step("no_phantom", 0, 1, 0, 0);

        cyc();
        cyc();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_min.md
COUNTER_MIN -- requirements
Module: counter_min

Interface
REQ-001 The block SHALL have parameter MAX_MIN, default 99, the upper bound on loadable minutes.
REQ-002 The block SHALL have parameter MIN_W, default 7, the width of the minutes value.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port sec_carry, input, 1: the seconds-stage toggle carry, where each level change = one seconds wrap (borrow).
REQ-006 The block SHALL have port sec_value, input, 6: the current seconds count from the seconds stage.
REQ-007 The block SHALL have port load, input, 1: a preset request, level-sampled each cycle.
REQ-008 The block SHALL have port preset_min, input, MIN_W: the minutes value applied on load.
REQ-009 The block SHALL have port run, input, 1: 1 = count this player's time, 0 = hold.
REQ-010 The block SHALL have port minutes, output, MIN_W: the current minutes remaining.
REQ-011 The block SHALL have port running, output, 1: high while in RUNNING.
REQ-012 The block SHALL have port flag, output, 1: time-expired level, held until load or reset.
REQ-013 The block SHALL have port flag_pulse, output, 1: a one-cycle strobe on entry to EXPIRED.

Function
REQ-014 The block SHALL detect a borrow on any cycle where sec_carry differs from its registered copy carry_q, and SHALL update carry_q every cycle.
REQ-015 The block SHALL implement states IDLE, RUNNING, PAUSED and EXPIRED.
REQ-016 The IDLE and PAUSED states SHALL transition to RUNNING when run=1 and load=0; they SHALL ignore borrows.
REQ-017 The RUNNING state SHALL transition to PAUSED on run=0 (that cycle's borrow discarded).
REQ-018 In RUNNING, on a borrow with minutes>0, the block SHALL set minutes to minutes-1, registered, with one-cycle latency from the sec_carry change.
REQ-019 In RUNNING, the block SHALL enter EXPIRED on a borrow with minutes=0, or whenever minutes=0 and sec_value=0.
REQ-020 The EXPIRED state SHALL set flag=1, SHALL hold minutes at 0, SHALL ignore run and borrows, and SHALL exit only on load or reset.
REQ-021 The block SHALL raise flag_pulse for exactly the one cycle in which the state becomes EXPIRED.
REQ-022 In any state, load=1 SHALL set minutes to min(preset_min, MAX_MIN), SHALL clear flag, and SHALL go to IDLE next cycle.
REQ-023 When load and borrow occur in the same cycle, load SHALL win and the borrow SHALL be discarded.
REQ-024 When load and run are both 1, load SHALL win; RUNNING starts the following cycle if run stays high.
REQ-025 Minutes SHALL never underflow below 0 and SHALL never exceed MAX_MIN; all arithmetic is unsigned in MIN_W bits.
REQ-026 The block SHALL derive running combinationally from state only.

Reset
REQ-027 While reset=1, the block SHALL set state=IDLE, minutes=0, flag=0, flag_pulse=0 and running=0.
REQ-028 While reset=1, carry_q SHALL load sec_carry, so that no phantom borrow occurs after release.
REQ-029 Reset SHALL take priority over load, run and borrow, including mid-count and in EXPIRED.

Structure
REQ-030 The shared package chess_timer_pkg SHALL hold the state enumeration, MAX_MIN, MIN_W and the seconds width 6.
REQ-031 The block SHALL contain one sub-module, toggle_detect, which converts the toggle carry into a one-cycle borrow pulse and supports the reset capture.
REQ-032 No other sub-modules SHALL be used; the target size is roughly 150-250 lines of RTL.

Verification
REQ-033 Bench case: load preset_min=3, then run=1, then toggle sec_carry once -> minutes=2 one cycle later, running=1.
REQ-034 Bench case: load preset_min=120 -> minutes=99 (clamped), state IDLE, flag=0.
REQ-035 Bench case: minutes=0 and RUNNING, then sec_value driven to 0 -> flag=1, flag_pulse high exactly one cycle, later toggles ignored, minutes stays 0.
REQ-036 Bench case: RUNNING with minutes=5, then load=1 (preset 10) in the same cycle as a sec_carry toggle -> minutes=10, IDLE, no decrement.
REQ-037 Bench case: run=0 with minutes=4, then two sec_carry toggles -> minutes stays 4 (PAUSED); run=1 then one toggle -> minutes=3.
REQ-038 Bench case: assert reset mid-count while sec_carry=1, then deassert -> all outputs 0, and no decrement on the first cycle after reset.
